fetch_sequencer: RTL and testbench

//  Multi-cycle fetch/execute controller for the program counter and instruction memory.
//  - Reads two words per instruction from memory at the current PC: opcode at PC, operand at PC+1.
//  - Pulses the PC advance strobe once per fetched word.
//  - Presents a stable {opcode, operand} pair to the PC/ALU/register datapath with a one-cycle start strobe.
//  - Waits for execution to complete before fetching the next instruction.

---
 rtl/fetch_pkg.sv | 29 ++
 rtl/fetch_mem_port.sv | 38 +++
 rtl/fetch_sequencer.sv | 108 ++++++++++
 tb/tb_fetch_sequencer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch sequencer and its neighbours (PC, decode).
package fetch_pkg;

  localparam int          FETCH_DW_DEF     = 16;
  localparam logic [15:0] HALT_OPCODE_DEF  = 16'hFFFF;

  // Opcode nibble that routes an instruction to the PC block, plus jump sub-ops.
  localparam logic [3:0]  PC_OP            = 4'b0111;
  localparam logic [3:0]  JMP_ALWAYS       = 4'h0;
  localparam logic [3:0]  JMP_ZERO         = 4'h1;
  localparam logic [3:0]  JMP_NZERO        = 4'h2;
  localparam logic [3:0]  JMP_CARRY        = 4'h3;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_OP_REQ    = 3'd1,
    S_OP_WAIT   = 3'd2,
    S_ARG_REQ   = 3'd3,
    S_ARG_WAIT  = 3'd4,
    S_EXEC      = 3'd5,
    S_WAIT_DONE = 3'd6,
    S_HALT      = 3'd7
  } fetch_state_e;

  function automatic logic is_wait(fetch_state_e s);
    return (s == S_OP_WAIT) || (s == S_ARG_WAIT);
  endfunction

endpackage

// File: rtl/fetch_mem_port.sv
// Instruction-memory read port: holds req/addr until ack and captures the
// returned word. One instance serves both opcode and operand fetches.
module fetch_mem_port #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] addr_in,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_req,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic                  ack_hit,
  output logic [DATA_WIDTH-1:0] word
);

  // An ack only counts against an outstanding request.
  assign ack_hit = mem_req & mem_ack;

  // Request hold and ack capture; reset drops any outstanding request.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_req  <= 1'b0;
      mem_addr <= '0;
      word     <= '0;
    end else begin
      if (start) begin
        mem_req  <= 1'b1;
        mem_addr <= addr_in;
      end else if (ack_hit) begin
        mem_req  <= 1'b0;
      end
      if (ack_hit) word <= mem_rdata;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch/execute controller: fetches opcode at PC and operand at PC+1, hands
// the pair to the datapath with exec_start, waits for exec_done, repeats.
// Optional feature macro: FETCH_SINGLE_STEP_EN (adds step_req gating).
module fetch_sequencer import fetch_pkg::*; #(
  parameter int                    DATA_WIDTH  = FETCH_DW_DEF,
  parameter logic [DATA_WIDTH-1:0] HALT_OPCODE = DATA_WIDTH'(HALT_OPCODE_DEF)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] pc_value,
  output logic                  pc_read_enable,
  output logic                  pc_advance,
  output logic                  mem_req,
  output logic [DATA_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] opcode,
  output logic [DATA_WIDTH-1:0] operand,
  output logic                  exec_start,
  input  logic                  exec_done,
`ifdef FETCH_SINGLE_STEP_EN
  input  logic                  step_req,
`endif
  output logic                  halted
);

  fetch_state_e          state_q, state_d;
  logic                  ack_hit;
  logic                  go_next;
  logic [DATA_WIDTH-1:0] word;

  fetch_mem_port #(.DATA_WIDTH(DATA_WIDTH)) u_port (
    .clk       (clk),
    .reset     (reset),
    .start     (pc_read_enable),
    .addr_in   (pc_value),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .ack_hit   (ack_hit),
    .word      (word)
  );

`ifdef FETCH_SINGLE_STEP_EN
  logic step_seen_q, done_seen_q;
  logic in_exec;

  assign in_exec = (state_q == S_EXEC) || (state_q == S_WAIT_DONE);
  assign go_next = (exec_done | done_seen_q) & (step_req | step_seen_q);

  // Remember done/step events from exec_start onward; drop them at OP_REQ.
  always_ff @(posedge clk) begin
    if (!reset) begin
      step_seen_q <= 1'b0;
      done_seen_q <= 1'b0;
    end else if (state_q == S_OP_REQ) begin
      step_seen_q <= 1'b0;
      done_seen_q <= 1'b0;
    end else if (in_exec) begin
      if (step_req)  step_seen_q <= 1'b1;
      if (exec_done) done_seen_q <= 1'b1;
    end
  end
`else
  assign go_next = exec_done;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; exec_done coincident with exec_start is honoured in EXEC.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      state_d = S_OP_REQ;
      S_OP_REQ:    state_d = S_OP_WAIT;
      S_OP_WAIT:   if (ack_hit) state_d = (mem_rdata == HALT_OPCODE) ? S_HALT : S_ARG_REQ;
      S_ARG_REQ:   state_d = S_ARG_WAIT;
      S_ARG_WAIT:  if (ack_hit) state_d = S_EXEC;
      S_EXEC:      state_d = go_next ? S_OP_REQ : S_WAIT_DONE;
      S_WAIT_DONE: if (go_next) state_d = S_OP_REQ;
      S_HALT:      state_d = S_HALT;
      default:     state_d = S_IDLE;
    endcase
  end

  // Moore outputs plus the ack-qualified PC advance strobe.
  always_comb begin
    pc_read_enable = (state_q == S_OP_REQ) || (state_q == S_ARG_REQ);
    pc_advance     = is_wait(state_q) & ack_hit;
    exec_start     = (state_q == S_EXEC);
    halted         = (state_q == S_HALT);
  end

  // The port's capture register holds the opcode until ARG_REQ, then the operand;
  // park the opcode here before the operand fetch overwrites it.
  always_ff @(posedge clk) begin
    if (!reset)                    opcode <= '0;
    else if (state_q == S_ARG_REQ) opcode <= word;
  end

  assign operand = word;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: stimulus pushes expected
// {opcode, operand, cycle} entries, a monitor pops them on exec_start.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] pc_value;
  logic        pc_read_enable, pc_advance, mem_req, mem_ack, exec_start, exec_done, halted;
  logic [15:0] mem_addr, mem_rdata, opcode, operand;
`ifdef FETCH_SINGLE_STEP_EN
  logic        step_req = 1'b0;
  logic        step_auto = 1'b1;
`endif

  fetch_sequencer dut (
    .clk(clk), .reset(reset), .pc_value(pc_value), .pc_read_enable(pc_read_enable),
    .pc_advance(pc_advance), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .opcode(opcode), .operand(operand), .exec_start(exec_start),
    .exec_done(exec_done),
`ifdef FETCH_SINGLE_STEP_EN
    .step_req(step_req),
`endif
    .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct { logic [15:0] op; logic [15:0] arg; int cyc; } exp_t;
  exp_t sb[$];

  int n_chk = 0;
  int n_fail = 0;
  logic [15:0] mem [0:63];
  int          dly [0:63];
  logic mem_en = 1'b0, force_ack = 1'b1;
  int   coinc_from = 1000;
  int   rel_cyc, adv_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // PC model, cycle counter since reset release, advance-pulse counter.
  always @(posedge clk) begin
    if (!reset) begin
      pc_value <= 16'h0; rel_cyc <= 1; adv_cnt <= 0;
    end else begin
      rel_cyc <= rel_cyc + 1;
      if (pc_advance) begin
        pc_value <= pc_value + 16'h1;
        adv_cnt  <= adv_cnt + 1;
      end
    end
  end

  // Memory responder: ack after dly[addr] wait cycles.
  int wcnt = 0;
  always @(posedge clk) begin
    #1;
    if (mem_en && mem_req) begin
      if (wcnt >= dly[mem_addr[5:0]]) begin
        mem_ack = 1'b1; mem_rdata = mem[mem_addr[5:0]]; wcnt = 0;
      end else begin
        mem_ack = 1'b0; wcnt++;
      end
    end else begin
      mem_ack = mem_en ? 1'b0 : force_ack;
      wcnt = 0;
    end
  end

  // Datapath model: exec_done next cycle, or coincident from instruction coinc_from on.
  logic pend = 1'b0;
  int   n_st = 0;
  always @(posedge clk) begin
    #1;
    if (!reset) begin
      exec_done = 1'b0; pend = 1'b0; n_st = 0;
    end else begin
      exec_done = pend; pend = 1'b0;
      if (exec_start) begin
        n_st++;
        if (n_st >= coinc_from) exec_done = 1'b1;
        else                    pend = 1'b1;
      end
    end
`ifdef FETCH_SINGLE_STEP_EN
    if (step_auto) step_req = 1'b1;
`endif
  end

  // Scoreboard monitor.
  always @(negedge clk) begin : mon
    exp_t e;
    if (reset === 1'b1 && exec_start === 1'b1) begin
      if (sb.size() == 0) chk("unexpected_exec_start", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        chk("opcode", 32'(opcode), 32'(e.op));
        chk("operand", 32'(operand), 32'(e.arg));
        if (e.cyc >= 0) chk("exec_cycle", 32'(rel_cyc), 32'(e.cyc));
      end
    end
  end

  task automatic wait_exec(input string name);
    logic seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (exec_start) seen = 1'b1;
    end
    chk(name, 32'(seen), 32'd1);
  endtask

  task automatic wait_halt(input string name);
    logic seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (halted) seen = 1'b1;
    end
    chk(name, 32'(seen), 32'd1);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) begin mem[i] = 16'h0; dly[i] = 0; end
  endtask

  initial begin
    int bad, w, a0;
    logic seen;
    reset = 1'b0; mem_ack = 1'b1; mem_rdata = 16'h0;
    clear_mem();

    // Reset held 3 cycles with ack asserted.
    repeat (3) @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_exec_start", 32'(exec_start), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_opcode", 32'(opcode), 32'd0);
    chk("rst_pc_read_enable", 32'(pc_read_enable), 32'd0);
    chk("rst_pc_advance", 32'(pc_advance), 32'd0);

    // Zero-wait fetch of two instructions, second with coincident exec_done, then HALT.
    mem[0] = 16'h7003; mem[1] = 16'h0005; mem[2] = 16'h1234; mem[3] = 16'hABCD; mem[4] = 16'hFFFF;
    coinc_from = 2; force_ack = 1'b0; mem_en = 1'b1;
    sb.push_back('{16'h7003, 16'h0005, 6});
    sb.push_back('{16'h1234, 16'hABCD, 12});
    reset = 1'b1;
    wait_exec("first_exec_timeout");
    chk("adv_after_first", 32'(adv_cnt), 32'd2);
    wait_halt("halt_timeout");
    chk("halt_cycle", 32'(rel_cyc), 32'd15);
    chk("adv_total", 32'(adv_cnt), 32'd5);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (mem_req || exec_start || pc_read_enable || !halted) bad++;
    end
    chk("halt_quiet", 32'(bad), 32'd0);
    chk("sb_empty_t2", 32'(sb.size()), 32'd0);

    // Operand fetch with 4 wait states: address held, single advance pulse.
    reset = 1'b0;
    repeat (2) @(negedge clk);
    clear_mem();
    mem[0] = 16'h7003; mem[1] = 16'h0005; dly[1] = 4; mem[2] = 16'hFFFF;
    coinc_from = 1000;
    sb.push_back('{16'h7003, 16'h0005, 10});
    reset = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (mem_req && mem_addr == 16'h0001) seen = 1'b1;
    end
    chk("arg_req_timeout", 32'(seen), 32'd1);
    bad = 0; w = 0; a0 = adv_cnt;
    for (int i = 0; i < 20 && mem_req; i++) begin
      if (mem_addr != 16'h0001) bad++;
      w++;
      @(negedge clk);
    end
    chk("arg_wait_cycles", 32'(w), 32'd5);
    chk("arg_addr_hold", 32'(bad), 32'd0);
    chk("arg_adv_pulses", 32'(adv_cnt - a0), 32'd1);
    wait_halt("halt_timeout_t3");
    chk("sb_empty_t3", 32'(sb.size()), 32'd0);

    // Reset during OP_WAIT with a coincident ack: word dropped, restart from IDLE.
    reset = 1'b0;
    repeat (2) @(negedge clk);
    dly[1] = 0;
    mem_en = 1'b0; force_ack = 1'b0;
    reset = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (mem_req) seen = 1'b1;
    end
    chk("op_wait_timeout", 32'(seen), 32'd1);
    reset = 1'b0; force_ack = 1'b1; mem_ack = 1'b1; mem_rdata = 16'h7777;
    @(negedge clk);
    chk("rstw_opcode", 32'(opcode), 32'd0);
    chk("rstw_operand", 32'(operand), 32'd0);
    chk("rstw_mem_req", 32'(mem_req), 32'd0);
    chk("rstw_halted", 32'(halted), 32'd0);
    @(negedge clk);
    force_ack = 1'b0; mem_en = 1'b1;
    sb.push_back('{16'h7003, 16'h0005, 6});
    reset = 1'b1;
    wait_exec("restart_exec_timeout");
    wait_halt("halt_timeout_t5");
    chk("sb_empty_t5", 32'(sb.size()), 32'd0);

`ifdef FETCH_SINGLE_STEP_EN
    // Single step: next fetch waits for step_req after exec_done.
    reset = 1'b0;
    step_auto = 1'b0; step_req = 1'b0;
    repeat (2) @(negedge clk);
    mem[2] = 16'h1234; mem[3] = 16'hABCD; mem[4] = 16'hFFFF;
    sb.push_back('{16'h7003, 16'h0005, 6});
    reset = 1'b1;
    wait_exec("step_exec_timeout");
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (mem_req || pc_read_enable) bad++;
    end
    chk("step_stall", 32'(bad), 32'd0);
    sb.push_back('{16'h1234, 16'hABCD, -1});
    step_req = 1'b1;
    @(negedge clk);
    chk("step_op_req", 32'(pc_read_enable), 32'd1);
    step_req = 1'b0;
    @(negedge clk);
    chk("step_mem_req", 32'(mem_req), 32'd1);
    wait_exec("step_exec2_timeout");
    step_auto = 1'b1;
    wait_halt("halt_timeout_t6");
    chk("sb_empty_t6", 32'(sb.size()), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
